// File: rtl/ads_multi_rx_if.sv
// AXI4-Stream sample channel carrying the sign-extended sample words,
// their channel index and the frame marker.
interface ads_multi_rx_if #(
  parameter int OW  = 32,
  parameter int IDW = 2
);
  logic           tvalid;
  logic           tready;
  logic [OW-1:0]  tdata;
  logic [IDW-1:0] tid;
  logic           tlast;

  modport master (output tvalid, output tdata, output tid, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tid, input  tlast, output tready);
endinterface

// File: rtl/ads_multi_rx.sv
// Multi-channel serial ADC capture: CH serial lines framed by one shared
// drdy strobe are deserialised into W-bit samples, admitted to a word FIFO
// as whole sets only, and streamed out with channel id and frame tlast.
module ads_multi_rx #(
  parameter int W     = 24,
  parameter int CH    = 4,
  parameter int OW    = 32,
  parameter int FRAME = 256,
  parameter int DEPTH = 64
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          external_en,
  input  logic          drdy,
  input  logic [CH-1:0] dout,
  ads_multi_rx_if.master m_axis,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);
  localparam int IDW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = $clog2(W);
  localparam int FW  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int EW  = OW + IDW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  state_t         state, state_d;
  logic           drdy_q;
  logic [W-1:0]   sr [CH];
  logic [BW-1:0]  bit_cnt;
  logic [IDW-1:0] pc;
  logic [FW-1:0]  set_cnt;
  logic           admit;

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [AW:0]    cnt;
  logic [AW+1:0]  occ;

  logic start, last_bit, last_ch, fits, push, ld, word_last;
  logic [EW-1:0] push_word;

  assign start     = (state == IDLE) && external_en && drdy && !drdy_q;
  assign last_bit  = (state == SHIFT) && (bit_cnt == BW'(1));
  assign last_ch   = (pc == IDW'(CH - 1));
  // Occupancy includes the word parked in the output register.
  assign occ       = (AW + 2)'(cnt) + (AW + 2)'(m_axis.tvalid);
  assign fits      = occ <= (AW + 2)'(DEPTH - CH);
  assign push      = (state == PUSH) && admit;
  assign ld        = (cnt != '0) && (!m_axis.tvalid || m_axis.tready);
  assign word_last = (set_cnt == FW'(FRAME - 1)) && last_ch;
  assign push_word = {word_last, pc, OW'($signed(sr[pc]))};

  // State register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state: frame on a drdy rising edge, shift W bits, push CH words.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start)    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = PUSH;
      PUSH:    if (last_ch)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Per-channel deserialisers; the MSB enters on the start cycle.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CH; c++) sr[c] <= '0;
    end else if (start) begin
      for (int unsigned c = 0; c < CH; c++) sr[c] <= W'(dout[c]);
    end else if (state == SHIFT) begin
      for (int unsigned c = 0; c < CH; c++) sr[c] <= {sr[c][W-2:0], dout[c]};
    end
  end

  // Bit/channel/set counters, whole-set admission and drop accounting.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      drdy_q   <= 1'b0;
      bit_cnt  <= '0;
      pc       <= '0;
      set_cnt  <= '0;
      admit    <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drdy_q <= drdy;
      unique case (state)
        IDLE: begin
          if (start)             bit_cnt <= BW'(W - 1);
          else if (!external_en) set_cnt <= '0;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt - BW'(1);
          if (last_bit) begin
            pc    <= '0;
            admit <= fits;
            if (!fits) begin
              overflow <= 1'b1;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            end
          end
        end
        PUSH: begin
          pc <= pc + IDW'(1);
          if (last_ch && admit)
            set_cnt <= (set_cnt == FW'(FRAME - 1)) ? '0 : set_cnt + FW'(1);
        end
        default: ;
      endcase
    end
  end

  // Word storage; contents need no reset since the pointers define validity.
  always_ff @(posedge sclk) begin
    if (push) mem[wptr] <= push_word;
  end

  // FIFO pointers and show-ahead output register feeding the stream.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tid    <= '0;
      m_axis.tlast  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (ld) begin
        {m_axis.tlast, m_axis.tid, m_axis.tdata} <= mem[rptr];
        rptr          <= rptr + AW'(1);
        m_axis.tvalid <= 1'b1;
      end else if (m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
      cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(ld);
    end
  end
endmodule

// File: tb/tb_ads_multi_rx.sv
// Scoreboard bench for ads_multi_rx (W=24, CH=4, OW=32, FRAME=256, DEPTH=64).
module tb_ads_multi_rx;
  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       external_en = 1'b0;
  logic       drdy = 1'b0;
  logic [3:0] dout = '0;
  logic       overflow;
  logic [15:0] drop_cnt;

  ads_multi_rx_if #(.OW(32), .IDW(2)) m_axis ();

  ads_multi_rx #(.W(24), .CH(4), .OW(32), .FRAME(256), .DEPTH(64)) dut (
    .sclk(sclk), .rst_n(rst_n), .external_en(external_en), .drdy(drdy),
    .dout(dout), .m_axis(m_axis), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_start = 0;
  int first_rise = -1;
  int pop_cnt = 0;
  int set_m = 0;
  logic [34:0] exp_q[$];
  logic [23:0] vv [4];

  always @(posedge sclk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake.
  always @(negedge sclk) begin
    if (rst_n) begin
      if (m_axis.tvalid && first_rise < 0) first_rise = cyc;
      if (m_axis.tvalid && m_axis.tready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none",
                   {m_axis.tdata, m_axis.tid, m_axis.tlast});
        end else begin
          check("word", {29'b0, m_axis.tdata, m_axis.tid, m_axis.tlast}, {29'b0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  // One drdy-framed set of 24 bits per channel, 32-cycle period.
  task automatic send_set(input logic [23:0] v [4], input bit admit, input int en_drop, input bit glitch);
    if (admit) begin
      for (int c = 0; c < 4; c++)
        exp_q.push_back({{{8{v[c][23]}}, v[c]}, 2'(c), (set_m == 255) && (c == 3)});
      set_m = (set_m == 255) ? 0 : set_m + 1;
      if (en_drop >= 0) set_m = 0;
    end
    for (int b = 0; b < 32; b++) begin
      if (b == 0) t_start = cyc + 1;
      drdy = glitch ? ((b < 2) || (b >= 5 && b < 8)) : (b < 4);
      for (int c = 0; c < 4; c++) dout[c] = (b < 24) ? v[c][23-b] : 1'b0;
      if (b == en_drop) external_en = 1'b0;
      tick();
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !m_axis.tvalid) done = 1'b1;
    end
    check("drain_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 64'(m_axis.tvalid), 64'd0);
    check({tag, "_tdata"}, 64'(m_axis.tdata), 64'd0);
    check({tag, "_tid"}, 64'(m_axis.tid), 64'd0);
    check({tag, "_tlast"}, 64'(m_axis.tlast), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    int pops0;
    m_axis.tready = 1'b1;
    #23;
    check_reset_outputs("rst0");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_reset_outputs("post_rst");

    // Negative full-scale samples and first-word latency.
    external_en = 1'b1;
    for (int c = 0; c < 4; c++) vv[c] = 24'h800001 + 24'(c);
    send_set(vv, 1'b1, -1, 1'b0);
    wait_drain();
    check("latency", 64'(first_rise - t_start), 64'd25);

    // Spurious drdy rising edge 5 cycles into a word.
    for (int c = 0; c < 4; c++) vv[c] = 24'hA5C30F ^ 24'(c << 4);
    send_set(vv, 1'b1, -1, 1'b1);

    // Positive full scale through the end of frame and the wrap.
    for (int c = 0; c < 4; c++) vv[c] = 24'h7FFFFF;
    while (set_m != 0) send_set(vv, 1'b1, -1, 1'b0);
    send_set(vv, 1'b1, -1, 1'b0);
    wait_drain();

    // Backpressure: 16 sets fill 64 words, the next 4 are dropped.
    check("pre_overflow", 64'(overflow), 64'd0);
    check("pre_drop_cnt", 64'(drop_cnt), 64'd0);
    m_axis.tready = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      for (int c = 0; c < 4; c++) vv[c] = {8'(s), 12'h0, 4'(c)} ^ ((s % 2) ? 24'h800000 : 24'h0);
      send_set(vv, s <= 16, -1, 1'b0);
    end
    check("overflow", 64'(overflow), 64'd1);
    check("drop_cnt", 64'(drop_cnt), 64'd4);
    check("full_tvalid", 64'(m_axis.tvalid), 64'd1);
    pops0 = pop_cnt;
    m_axis.tready = 1'b1;
    wait_drain();
    check("full_words", 64'(pop_cnt - pops0), 64'd64);

    // Reset while 30 words are buffered.
    m_axis.tready = 1'b0;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) vv[c] = 24'h123400 + 24'(s * 4 + c);
      send_set(vv, 1'b1, -1, 1'b0);
    end
    m_axis.tready = 1'b1;
    tick();
    tick();
    m_axis.tready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    set_m = 0;
    tick();
    tick();
    rst_n = 1'b1;
    m_axis.tready = 1'b1;
    tick();
    check("post_rst_tvalid", 64'(m_axis.tvalid), 64'd0);

    // Enable drop mid-SHIFT of set 10; re-enable realigns the frame.
    external_en = 1'b1;
    for (int s = 0; s < 11; s++) begin
      for (int c = 0; c < 4; c++) vv[c] = {4'(c), 20'h0, 4'(s)} + 24'h0A0000;
      send_set(vv, 1'b1, (s == 10) ? 12 : -1, 1'b0);
    end
    for (int s = 0; s < 2; s++) send_set(vv, 1'b0, -1, 1'b0);
    wait_drain();
    external_en = 1'b1;
    tick();
    for (int s = 0; s < 256; s++) begin
      for (int c = 0; c < 4; c++) vv[c] = 24'h00F000 + 24'(s);
      send_set(vv, 1'b1, -1, 1'b0);
    end
    wait_drain();
    check("final_drop_cnt", 64'(drop_cnt), 64'd0);
    check("leftover", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
